logic_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single registered bitwise logic unit (AND, OR, NOT, XOR) among `N_REQ` requesters. Each requester presents an opcode and two operands. The block grants one requester at a time, latches its operands, computes the result, and returns it tagged with the requester index. The returned result is held under a valid/ready handshake. The block sits between the gate datapath and the client blocks that need gate operations.

---
 rtl/logic_unit_arbiter.sv | 142 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that shares one registered bitwise logic unit (AND/OR/NOT/XOR)
// among N_REQ requesters and returns each result tagged with its requester index.
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] a_in,
    input  logic [WIDTH*N_REQ-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IDW-1:0]         res_id,
    output logic [WIDTH-1:0]       res_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]       op_arr [N_REQ];
    logic [WIDTH-1:0] a_arr  [N_REQ];
    logic [WIDTH-1:0] b_arr  [N_REQ];

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nxt;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   win_id;
    logic             win_found;
    logic [N_REQ-1:0] win_onehot;

    logic [1:0]       lat_op;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_arr[g] = op[2*g +: 2];
        assign a_arr[g]  = a_in[WIDTH*g +: WIDTH];
        assign b_arr[g]  = b_in[WIDTH*g +: WIDTH];
    end

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] code,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (code)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~a;
            default: return a ^ b;
        endcase
    endfunction

    // Rotating priority search: first set request at or above ptr, wrapping around.
    always_comb begin : search
        logic [IDW-1:0] cand;
        // NOTE: every variable gets a default before any conditional write, otherwise a latch is inferred.
        cand       = '0;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found        = 1'b1;
                win_idx          = cand;
                win_onehot       = '0;
                win_onehot[cand] = 1'b1;
            end
        end
        ptr_nxt = IDW'((int'(win_idx) + 1) % N_REQ);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (res_valid && res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath registers: grant/latch in IDLE, compute in EXEC, hold in RESP until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            gnt       <= '0;
            win_id    <= '0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt <= win_onehot;
                    if (win_found) begin
                        win_id <= win_idx;
                        lat_op <= op_arr[win_idx];
                        lat_a  <= a_arr[win_idx];
                        lat_b  <= b_arr[win_idx];
                        ptr    <= ptr_nxt;
                    end
                end
                EXEC: begin
                    gnt       <= '0;
                    res_data  <= logic_op(lat_op, lat_a, lat_b);
                    res_id    <= win_id;
                    res_valid <= 1'b1;
                end
                RESP: begin
                    gnt <= '0;
                    if (res_valid && res_ready) res_valid <= 1'b0;
                end
                default: gnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a transaction-level model predicts grants
// and results; a negedge monitor compares the DUT against it every cycle.
module tb_logic_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [2*N-1:0] op;
    logic [W*N-1:0] a_in;
    logic [W*N-1:0] b_in;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           res_valid;
    logic           res_ready;
    logic [1:0]     res_id;
    logic [W-1:0]   res_data;

    logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_fn(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~a;
            default: return a ^ b;
        endcase
    endfunction

    typedef struct { int id; logic [W-1:0] data; } resp_t;
    typedef struct { int idx; int cyc; } glog_t;

    resp_t        exp_q[$];
    glog_t        gnt_log[$];
    int           m_ptr    = 0;
    int           m_phase  = 0;   // 0 free, 1 computing, 2 result offered
    int           cyc      = 0;
    int           w;
    bit           found;
    bit           mon_en   = 0;
    bit           exp_fresh = 0;
    bit           exp_rst  = 0;
    bit           exp_valid = 0;
    logic [N-1:0] exp_gnt  = '0;

    // Reference model, evaluated from the inputs sampled at each rising edge.
    always @(posedge clk) begin
        cyc++;
        mon_en    = 1;
        exp_fresh = 0;
        exp_rst   = 0;
        if (!rst_n) begin
            m_ptr = 0; m_phase = 0; exp_gnt = '0; exp_valid = 0; exp_rst = 1;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    exp_gnt = '0;
                    found   = 0;
                    w       = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && (((req >> ((m_ptr + k) % N)) & 4'b0001) != 0)) begin
                            found = 1;
                            w     = (m_ptr + k) % N;
                        end
                    end
                    if (found) begin
                        exp_q.push_back('{w, ref_fn(2'(op >> (2*w)), W'(a_in >> (W*w)),
                                                    W'(b_in >> (W*w)))});
                        exp_gnt = N'(1 << w);
                        m_ptr   = (w + 1) % N;
                        m_phase = 1;
                    end
                end
                1: begin
                    exp_gnt = '0; exp_valid = 1; exp_fresh = 1; m_phase = 2;
                end
                default: if (res_ready) begin
                    exp_valid = 0; m_phase = 0;
                end
            endcase
        end
    end

    int           hold_id   = 0;
    logic [W-1:0] hold_data = '0;
    resp_t        popped;

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt", gnt, exp_gnt);
            check("res_valid", res_valid, exp_valid);
            check("busy", busy, (m_phase != 0));
            if (exp_rst) begin
                hold_id = 0; hold_data = '0;
            end
            if (exp_fresh) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    popped    = exp_q.pop_front();
                    hold_id   = popped.id;
                    hold_data = popped.data;
                end
            end
            check("res_id", res_id, hold_id);
            check("res_data", res_data, hold_data);
            for (int k = 0; k < N; k++)
                if (((gnt >> k) & 4'b0001) != 0) gnt_log.push_back('{k, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [W-1:0] t2_exp [4];
    int           fair_order [6];

    initial begin
        t2_exp     = '{8'h30, 8'hFC, 8'h0F, 8'hCC};
        fair_order = '{0, 1, 2, 3, 0, 1};

        // Reset with all requests high.
        rst_n = 1'b0; req = 4'b1111; res_ready = 1'b1;
        op = 8'($urandom); a_in = $urandom; b_in = $urandom;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("first_gnt", gnt, 4'b0001);
        req = '0;
        wait_idle(20);

        // Single requester, every opcode.
        a_in = '0; b_in = '0; op = '0;
        a_in[23:16] = 8'hF0;
        b_in[23:16] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            op[5:4] = 2'(i);
            req = 4'b0100;
            tick();
            check("t2_gnt", gnt, 4'b0100);
            req = '0;
            tick();
            check("t2_valid", res_valid, 1'b1);
            check("t2_id", res_id, 2);
            check("t2_data", res_data, t2_exp[i]);
            tick();
        end
        wait_idle(20);

        // Fairness under continuous full request.
        pulse_reset();
        gnt_log.delete();
        req = 4'b1111;
        op = 8'($urandom); a_in = $urandom; b_in = $urandom;
        repeat (18) tick();
        req = '0;
        wait_idle(20);
        check("fair_count", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
            check("fair_order", gnt_log[i].idx, fair_order[i]);
            if (i > 0) check("fair_spacing", gnt_log[i].cyc - gnt_log[i-1].cyc, 3);
        end

        // Backpressure while other requests wait.
        res_ready = 1'b0;
        req = 4'b0001;
        tick();
        req = 4'b1110;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", res_valid, 1'b1);
            check("bp_gnt", gnt, 4'b0000);
        end
        res_ready = 1'b1;
        tick();
        check("bp_release_valid", res_valid, 1'b0);
        check("bp_release_gnt", gnt, 4'b0000);
        tick();
        check("bp_next_gnt", gnt, 4'b0010);
        req = '0;
        wait_idle(20);

        // Pointer behaviour around the wrap.
        pulse_reset();
        req = 4'b1000;
        tick();
        req = '0;
        wait_idle(20);
        req = 4'b1001;
        tick();
        check("ptr_after_3", gnt, 4'b0001);
        req = '0;
        wait_idle(20);
        req = 4'b0010;
        tick();
        req = '0;
        wait_idle(20);
        req = 4'b1001;
        tick();
        check("ptr_after_1", gnt, 4'b1000);
        req = '0;
        wait_idle(20);

        // Reset during EXEC, then during RESP.
        req = 4'b0100;
        tick();
        req = '0;
        rst_n = 1'b0;
        tick();
        check("rst_exec_valid", res_valid, 1'b0);
        check("rst_exec_gnt", gnt, 4'b0000);
        rst_n = 1'b1;
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_resp_valid", res_valid, 1'b0);
        check("rst_resp_gnt", gnt, 4'b0000);
        check("rst_resp_data", res_data, 8'h00);
        rst_n = 1'b1;
        req = 4'b1100;
        tick();
        check("rst_next_gnt", gnt, 4'b0100);
        req = '0;
        wait_idle(20);

        // Randomized traffic with backpressure and occasional resets.
        for (int i = 0; i < 600; i++) begin
            req       = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            op        = 8'($urandom);
            a_in      = $urandom;
            b_in      = $urandom;
            res_ready = ($urandom_range(0, 9) < 7);
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
        end

        rst_n = 1'b1; req = '0; res_ready = 1'b1;
        wait_idle(20);
        tick();
        check("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
